// File: rtl/dm_bus_ctrl_pkg.sv
// Shared encodings for the memory-stage bus controller: access sizes,
// exception codes, the controller FSM states and a lane-mask helper.
package dm_bus_ctrl_pkg;

  localparam logic [1:0] SZ_W   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_B   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_e;

  // Expand a 4-bit byte enable into a 32-bit data mask.
  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dm_bus_ctrl_addr_decode.sv
// Combinational address map and access check: one-hot target select,
// alignment / window / read-only checks and byte enables for a request.
module dm_addr_decode
  import dm_bus_ctrl_pkg::*;
#(
  parameter logic [31:0] DM_TOP     = 32'h0000_2fff,
  parameter int unsigned NUM_DEV    = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
  parameter logic [31:0] DEV_STRIDE = 32'h0000_0010,
  parameter logic [3:0]  CNT_OFS    = 4'h8,
  parameter logic [31:0] IG_BASE    = 32'h0000_7f20
) (
  input  logic [31:0]        addr_i,
  input  logic [1:0]         size_i,
  input  logic               we_i,
  output logic [NUM_DEV+1:0] sel_o,
  output logic               noop_o,
  output logic               err_o,
  output logic [4:0]         exc_o,
  output logic [3:0]         byteen_o
);

  logic        in_dev;
  logic        cnt_hit;
  logic        misalign;
  logic        bad;
  logic [31:0] dev_lo;
  logic [31:0] cnt_adr;

  // Map the address onto DM, a device window or the interrupt generator.
  always_comb begin
    sel_o   = '0;
    in_dev  = 1'b0;
    cnt_hit = 1'b0;
    dev_lo  = '0;
    cnt_adr = '0;
    if (addr_i <= DM_TOP) sel_o[0] = 1'b1;
    for (int unsigned k = 0; k < NUM_DEV; k++) begin
      dev_lo  = DEV_BASE + k * DEV_STRIDE;
      cnt_adr = dev_lo + {28'd0, CNT_OFS};
      if (addr_i >= dev_lo && addr_i <= dev_lo + 32'd11) begin
        sel_o[k+1] = 1'b1;
        in_dev     = 1'b1;
      end
      if ({addr_i[31:2], 2'b00} == cnt_adr) cnt_hit = 1'b1;
    end
    if (addr_i >= IG_BASE && addr_i <= IG_BASE + 32'd3) sel_o[NUM_DEV+1] = 1'b1;
  end

  // Classify the request and derive the byte lanes it touches.
  always_comb begin
    noop_o   = (size_i == SZ_RSV);
    misalign = ((size_i == SZ_W) && (addr_i[1:0] != 2'b00)) ||
               ((size_i == SZ_H) && addr_i[0]);
    bad      = (~|sel_o) || misalign || (in_dev && (size_i != SZ_W)) ||
               (we_i && cnt_hit);
    err_o    = bad & ~noop_o;
    exc_o    = err_o ? (we_i ? EXC_ADES : EXC_ADEL) : EXC_NONE;
    case (size_i)
      SZ_W:    byteen_o = 4'b1111;
      SZ_H:    byteen_o = addr_i[1] ? 4'b1100 : 4'b0011;
      SZ_B:    byteen_o = 4'b0001 << addr_i[1:0];
      default: byteen_o = 4'b0000;
    endcase
  end

endmodule

// File: rtl/dm_bus_ctrl.sv
// Sequential, handshaked load/store bus master for the memory stage.
// Stalls the pipeline until the selected target acks or the access times out.
module dm_bus_ctrl
  import dm_bus_ctrl_pkg::*;
#(
  parameter logic [31:0] DM_TOP     = 32'h0000_2fff,
  parameter int unsigned NUM_DEV    = 2,
  parameter logic [31:0] DEV_BASE   = 32'h0000_7f00,
  parameter logic [31:0] DEV_STRIDE = 32'h0000_0010,
  parameter logic [3:0]  CNT_OFS    = 4'h8,
  parameter logic [31:0] IG_BASE    = 32'h0000_7f20,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_sign,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               stall,
  output logic               done,
  output logic [31:0]        rdata,
  output logic [4:0]         exc_code,
  output logic               bus_req,
  output logic [NUM_DEV+1:0] bus_sel,
  output logic [31:0]        bus_addr,
  output logic [3:0]         bus_byteen,
  output logic [31:0]        bus_wdata,
  input  logic               bus_ack,
  input  logic [31:0]        bus_rdata
);

  localparam logic [7:0] CNT_LIM = 8'(TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [NUM_DEV+1:0] sel_q, sel_d;
  logic [31:0]        addr_q, addr_d;
  logic [3:0]         byteen_q, byteen_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               sign_q, sign_d;
  logic [4:0]         exc_q, exc_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [NUM_DEV+1:0] dec_sel;
  logic               dec_noop;
  logic               dec_err;
  logic [4:0]         dec_exc;
  logic [3:0]         dec_byteen;
  logic [31:0]        wd_rep;
  logic [31:0]        wd_lane;
  logic [15:0]        rd_half;
  logic [7:0]         rd_byte;
  logic [31:0]        load_word;

  dm_addr_decode #(
    .DM_TOP     (DM_TOP),
    .NUM_DEV    (NUM_DEV),
    .DEV_BASE   (DEV_BASE),
    .DEV_STRIDE (DEV_STRIDE),
    .CNT_OFS    (CNT_OFS),
    .IG_BASE    (IG_BASE)
  ) u_decode (
    .addr_i   (req_addr),
    .size_i   (req_size),
    .we_i     (req_we),
    .sel_o    (dec_sel),
    .noop_o   (dec_noop),
    .err_o    (dec_err),
    .exc_o    (dec_exc),
    .byteen_o (dec_byteen)
  );

  // Replicate store data across lanes, then keep only the enabled ones.
  always_comb begin
    case (req_size)
      SZ_H:    wd_rep = {2{req_wdata[15:0]}};
      SZ_B:    wd_rep = {4{req_wdata[7:0]}};
      default: wd_rep = req_wdata;
    endcase
    wd_lane = wd_rep & lane_mask(dec_byteen);
  end

  // Pick the addressed lane of the returned word and extend it.
  always_comb begin
    rd_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (addr_q[1:0])
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    case (size_q)
      SZ_H:    load_word = sign_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
      SZ_B:    load_word = sign_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
      default: load_word = bus_rdata;
    endcase
  end

  // Next-state logic: accept or reject in IDLE, wait for ack or timeout in ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    byteen_d = byteen_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    sign_d   = sign_q;
    exc_d    = exc_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          exc_d    = dec_exc;
          rdata_d  = '0;
          byteen_d = '0;
          wdata_d  = '0;
          cnt_d    = '0;
          if (dec_err || dec_noop) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCESS;
            sel_d   = dec_sel;
            addr_d  = req_addr;
            size_d  = req_size;
            sign_d  = req_sign;
            if (req_we) begin
              byteen_d = dec_byteen;
              wdata_d  = wd_lane;
            end
          end
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // An ack in the limit cycle is checked first, so it wins over the timeout.
        if (bus_ack) begin
          rdata_d = load_word;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LIM) begin
          exc_d   = EXC_DBE;
          rdata_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        byteen_d = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and latched access registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      addr_q   <= '0;
      byteen_q <= '0;
      wdata_q  <= '0;
      size_q   <= SZ_W;
      sign_q   <= 1'b0;
      exc_q    <= EXC_NONE;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      byteen_q <= byteen_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      exc_q    <= exc_d;
      rdata_q  <= rdata_d;
    end
  end

  assign done       = (state_q == ST_DONE);
  assign bus_req    = (state_q == ST_ACCESS);
  assign stall      = req_valid & ~done;
  assign bus_sel    = bus_req ? sel_q : '0;
  assign bus_addr   = {addr_q[31:2], 2'b00};
  assign bus_byteen = byteen_q;
  assign bus_wdata  = wdata_q;
  assign rdata      = rdata_q;
  assign exc_code   = exc_q;

endmodule

// File: doc/dm_bus_ctrl.md
Name: dm_bus_ctrl

Overview:
- Memory-stage load/store controller: replaces the purely combinational data-memory control path with a sequential, handshaked bus master.
- Checks alignment and address map for a parametrised number of timer-style devices.
- Generates byte enables and lane-shifted write data, drives a one-hot req/ack bus to DM, the devices and the interrupt generator (IG), and extracts/extends load data.
- Stalls the pipeline until completion and raises AdEL/AdES/DBE (data bus error) on timeout.

Parameters:
- DM_TOP, 32'h0000_2fff, last byte address of data memory (DM spans 0..DM_TOP).
- NUM_DEV, 2, number of timer devices; device k spans DEV_BASE+k*DEV_STRIDE .. +11.
- DEV_BASE, 32'h0000_7f00, base address of device 0.
- DEV_STRIDE, 32'h10, address distance between consecutive devices.
- CNT_OFS, 4'h8, offset of each device's read-only count register.
- IG_BASE, 32'h0000_7f20, interrupt generator word (IG_BASE..IG_BASE+3).
- TIMEOUT, 16, cycles in ACCESS without bus_ack before DBE; legal range 2..255.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  M-stage holds a load/store; held stable while stall=1
- req_we  in  1  1=store, 0=load
- req_size  in  2  00 word, 01 half, 10 byte, 11 reserved (treated as no-op, done with exc 0)
- req_sign  in  1  load sign-extend (1) / zero-extend (0)
- req_addr  in  32  byte address
- req_wdata  in  32  store data (unshifted, low bits valid)
- stall  out  1  req_valid & ~done
- done  out  1  one-cycle completion pulse
- rdata  out  32  extended load data, valid when done
- exc_code  out  5  0 none, 4 AdEL, 5 AdES, 7 DBE; valid when done
- bus_req  out  1  access request, held until bus_ack or timeout
- bus_sel  out  NUM_DEV+2  one-hot: bit0 DM, bit1+k device k, bit NUM_DEV+1 IG
- bus_addr  out  32  {req_addr[31:2],2'b00}
- bus_byteen  out  4  byte lanes written (0000 on loads)
- bus_wdata  out  32  lane-shifted store data
- bus_ack  in  1  selected target completed (rdata valid same cycle)
- bus_rdata  in  32  raw word from target

Behaviour:
- FSM IDLE -> ACCESS -> DONE -> IDLE; state, counter and all registered outputs reset to IDLE/0 (bus_req=0, done=0, exc_code=0, rdata=0, bus_byteen=0).
- Exception check, combinational on the request, evaluated in IDLE:
  - Unmapped address: load -> AdEL, store -> AdES.
  - Word access with addr[1:0]!=0, or half with addr[0]!=0: AdEL/AdES.
  - Half or byte access to any device window: AdEL/AdES. IG accepts all sizes.
  - Store of any size to a device count register (device base + CNT_OFS): AdES.
- IDLE & req_valid & exception: go to DONE with exc latched; bus_req is never asserted and byteen stays 0.
- IDLE & req_valid & ok: latch select, byteen, wdata and addr lanes; go to ACCESS with bus_req=1 from the next cycle. Earliest done is 2 cycles after req_valid.
- ACCESS: the counter increments each cycle.
  - bus_ack: latch the extracted load word, go to DONE.
  - Counter reaches TIMEOUT-1 without ack: go to DONE with exc 7 and rdata 0.
  - bus_ack in the same cycle as the counter limit: ack wins.
- DONE: done=1 for exactly one cycle; bus_req=0; return to IDLE. A new request can be accepted on the following cycle.
- Byte enables:
  - W: 1111.
  - H: addr[1]=0 -> 0011, addr[1]=1 -> 1100.
  - B: one-hot 1<<addr[1:0].
- Write data: the half or byte is replicated or shifted into the selected lane(s); unselected lanes are 0.
- Load extraction: select the lane from bus_rdata by latched addr[1:0], then sign- or zero-extend per req_sign; word loads pass through unchanged.
- Reset asserted mid-ACCESS: bus_req drops at the next edge; any late bus_ack is ignored.
- bus_ack outside ACCESS is ignored.
- req_valid deasserted mid-ACCESS (flush) is not supported; the access completes.

Decomposition:
- Shared package holds:
  - Size encodings SZ_W/SZ_H/SZ_B.
  - Exception codes EXC_NONE, EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7.
  - FSM state enum.
- One sub-module, dm_addr_decode: combinational address map, exception check, one-hot bus_sel and byteen, reused later by the instruction-fetch side.

Test Plan:
- Store byte 0xA5 to 0x0000_0103, ack after 3 cycles -> bus_byteen=1000, bus_wdata=0xA500_0000, done 5 cycles after req_valid, exc 0.
- Load half, sign=1, at 0x0000_0002; bus_rdata=0x8001_1234 -> rdata=0xFFFF_8001. With sign=0 -> rdata=0x0000_8001.
- Store word to 0x7f18 (device 1 count) -> exc 5 after 1 cycle, bus_req never 1. Load byte from 0x7f04 -> exc 4.
- Load word from 0x0000_4000 (unmapped) -> exc 4; load word from 0x0000_0006 -> exc 4 (misaligned).
- Load word from DM, no ack, TIMEOUT=16 -> bus_req high 16 cycles, then done with exc 7 and stall released. Ack on the 16th cycle -> exc 0.
- Reset asserted in the 2nd ACCESS cycle -> bus_req=0, done=0 at the next edge; a subsequent request proceeds normally.
